// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and serial engine state codes
// for the AXI4-Lite UART.
package uart_pkg;

  localparam logic [3:0] REG_CONTROL = 4'h0;
  localparam logic [3:0] REG_STATUS  = 4'h1;
  localparam logic [3:0] REG_TX_DATA = 4'h2;
  localparam logic [3:0] REG_RX_DATA = 4'h3;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_RX_EN   = 1;
  localparam int CTRL_CLR_ERR = 2;

  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_BUSY   = 4;
  localparam int ST_OVERRUN   = 5;
  localparam int ST_FRAME_ERR = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with occupancy counter; pushes when full and pops when
// empty are ignored, simultaneous push and pop leave the count unchanged.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/axi_uart_top.sv
// AXI4-Lite register slave with TX/RX byte FIFOs and an 8N1 UART transmitter
// and receiver running at CLK_HZ/BAUD clocks per bit.
module axi_uart_top
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        tx_serial,
  input  logic        rx_serial
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  logic        tx_en_r, rx_en_r, ovr_r, ferr_r;
  logic        wr_hs_s, wr_en_s, rd_hs_s, clr_err_s;
  logic [3:0]  wr_idx_s, rd_idx_s;
  logic [31:0] rd_mux_s, status_s;

  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic [7:0]  tx_dout_s;
  logic [1:0]  tx_state_r;
  logic [CW-1:0] tx_cnt_r;
  logic [2:0]  tx_bit_r;
  logic [7:0]  tx_shift_r;

  logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s, rx_done_s, rx_fall_s;
  logic [7:0]  rx_dout_s;
  logic [1:0]  rx_state_r;
  logic [CW-1:0] rx_cnt_r;
  logic [2:0]  rx_bit_r;
  logic [7:0]  rx_shift_r;
  logic        rx_meta_r, rx_sync_r, rx_prev_r;

  logic        unused_s;
  assign unused_s = ^{awaddr[31:6], awaddr[1:0], araddr[31:6], araddr[1:0],
                      wdata[31:8], wstrb[3:1]};

  assign bresp     = 2'b00;
  assign rresp     = 2'b00;
  assign wr_hs_s   = awready && awvalid && wvalid;
  assign wr_en_s   = wr_hs_s && wstrb[0];
  assign wr_idx_s  = awaddr[5:2];
  assign rd_hs_s   = arready && arvalid;
  assign rd_idx_s  = araddr[5:2];
  assign clr_err_s = wr_en_s && (wr_idx_s == REG_CONTROL) && wdata[CTRL_CLR_ERR];
  assign tx_push_s = wr_en_s && (wr_idx_s == REG_TX_DATA);
  assign tx_pop_s  = (tx_state_r == S_IDLE) && tx_en_r && !tx_empty_s;
  assign rx_pop_s  = rd_hs_s && (rd_idx_s == REG_RX_DATA) && !rx_empty_s;
  assign rx_fall_s = rx_prev_r && !rx_sync_r;
  assign rx_done_s = (rx_state_r == S_STOP) && (rx_cnt_r == CNT_LAST);
  assign rx_push_s = rx_done_s && rx_sync_r && !rx_full_s;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(aclk), .rst_n(aresetn), .push(tx_push_s), .pop(tx_pop_s),
    .din(wdata[7:0]), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(aclk), .rst_n(aresetn), .push(rx_push_s), .pop(rx_pop_s),
    .din(rx_shift_r), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  // status word and read-data selection
  always_comb begin
    status_s               = 32'h0;
    status_s[ST_TX_EMPTY]  = tx_empty_s;
    status_s[ST_TX_FULL]   = tx_full_s;
    status_s[ST_RX_VALID]  = !rx_empty_s;
    status_s[ST_RX_FULL]   = rx_full_s;
    status_s[ST_TX_BUSY]   = (tx_state_r != S_IDLE);
    status_s[ST_OVERRUN]   = ovr_r;
    status_s[ST_FRAME_ERR] = ferr_r;
    rd_mux_s = 32'h0;
    case (rd_idx_s)
      REG_CONTROL: begin
        rd_mux_s[CTRL_TX_EN] = tx_en_r;
        rd_mux_s[CTRL_RX_EN] = rx_en_r;
      end
      REG_STATUS:  rd_mux_s = status_s;
      REG_RX_DATA: rd_mux_s = {23'h0, !rx_empty_s, (rx_empty_s ? 8'h00 : rx_dout_s)};
      default:     rd_mux_s = 32'h0;
    endcase
  end

  // write channel handshake, response and CONTROL register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      tx_en_r <= 1'b0;
      rx_en_r <= 1'b0;
    end else begin
      awready <= awvalid && wvalid && !bvalid && !awready;
      wready  <= awvalid && wvalid && !bvalid && !awready;
      if (wr_hs_s)     bvalid <= 1'b1;
      else if (bready) bvalid <= 1'b0;
      if (wr_en_s && (wr_idx_s == REG_CONTROL)) begin
        tx_en_r <= wdata[CTRL_TX_EN];
        rx_en_r <= wdata[CTRL_RX_EN];
      end
    end
  end

  // read channel; rdata is captured at the address handshake and held
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      arready <= arvalid && !rvalid && !arready;
      if (rd_hs_s) begin
        rvalid <= 1'b1;
        rdata  <= rd_mux_s;
      end else if (rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  // transmitter: start, 8 data bits LSB first, stop, each DIV clocks
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state_r <= S_IDLE;
      tx_cnt_r   <= {CW{1'b0}};
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'h00;
      tx_serial  <= 1'b1;
    end else begin
      case (tx_state_r)
        S_IDLE: if (tx_pop_s) begin
          tx_shift_r <= tx_dout_s;
          tx_cnt_r   <= {CW{1'b0}};
          tx_serial  <= 1'b0;
          tx_state_r <= S_START;
        end
        S_START: if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_r   <= {CW{1'b0}};
          tx_bit_r   <= 3'd0;
          tx_serial  <= tx_shift_r[0];
          tx_state_r <= S_DATA;
        end else tx_cnt_r <= tx_cnt_r + CNT_ONE;
        S_DATA: if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_r <= {CW{1'b0}};
          if (tx_bit_r == 3'd7) begin
            tx_serial  <= 1'b1;
            tx_state_r <= S_STOP;
          end else begin
            tx_bit_r   <= tx_bit_r + 3'd1;
            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
            tx_serial  <= tx_shift_r[1];
          end
        end else tx_cnt_r <= tx_cnt_r + CNT_ONE;
        S_STOP: if (tx_cnt_r == CNT_LAST) begin
          tx_cnt_r   <= {CW{1'b0}};
          tx_state_r <= S_IDLE;
        end else tx_cnt_r <= tx_cnt_r + CNT_ONE;
        default: begin
          tx_state_r <= S_IDLE;
          tx_serial  <= 1'b1;
        end
      endcase
    end
  end

  // two-flop synchronizer plus previous value for falling-edge detection
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_serial;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // receiver: start is re-checked at mid-bit, later samples land mid-bit too
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_state_r <= S_IDLE;
      rx_cnt_r   <= {CW{1'b0}};
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'h00;
    end else begin
      case (rx_state_r)
        S_IDLE: if (rx_en_r && rx_fall_s) begin
          rx_cnt_r   <= {CW{1'b0}};
          rx_state_r <= S_START;
        end
        S_START: if (rx_cnt_r == CNT_HALF) begin
          rx_cnt_r   <= {CW{1'b0}};
          rx_bit_r   <= 3'd0;
          rx_state_r <= rx_sync_r ? S_IDLE : S_DATA;
        end else rx_cnt_r <= rx_cnt_r + CNT_ONE;
        S_DATA: if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_r   <= {CW{1'b0}};
          rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
          rx_bit_r   <= rx_bit_r + 3'd1;
          if (rx_bit_r == 3'd7) rx_state_r <= S_STOP;
        end else rx_cnt_r <= rx_cnt_r + CNT_ONE;
        S_STOP: if (rx_cnt_r == CNT_LAST) begin
          rx_cnt_r   <= {CW{1'b0}};
          rx_state_r <= S_IDLE;
        end else rx_cnt_r <= rx_cnt_r + CNT_ONE;
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end

  // sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ovr_r  <= 1'b0;
      ferr_r <= 1'b0;
    end else begin
      if (rx_done_s && rx_sync_r && rx_full_s) ovr_r <= 1'b1;
      else if (clr_err_s)                      ovr_r <= 1'b0;
      if (rx_done_s && !rx_sync_r) ferr_r <= 1'b1;
      else if (clr_err_s)          ferr_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_uart_top.sv
// Randomized bench for axi_uart_top: AXI register traffic and serial frames
// checked against a queue-based model of the FIFOs, flags and line format.
module tb_axi_uart_top;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * DIV + 2;

  logic        aclk, aresetn;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        tx_serial, rx_serial, rx_drive, loop_en;

  int          n_checks, n_pass;
  logic [7:0]  m_rx[$];
  logic [7:0]  m_txq[$];
  logic [7:0]  tx_seen[$];
  logic        m_ovr, m_ferr;
  int          m_tx_cnt;

  assign rx_serial = loop_en ? tx_serial : rx_drive;

  axi_uart_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(16)) uart_top (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .tx_serial(tx_serial), .rx_serial(rx_serial)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_status();
    return {25'h0, m_ferr, m_ovr, 1'b0, (m_rx.size() == 16), (m_rx.size() != 0),
            (m_tx_cnt == 16), (m_tx_cnt == 0)};
  endfunction

  // passive line decoder on tx_serial: mid-bit sampling of 8N1 frames
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx_serial);
      repeat (DIV / 2) @(negedge aclk);
      if (tx_serial === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge aclk);
          b[i] = tx_serial;
        end
        repeat (DIV) @(negedge aclk);
        if (tx_serial === 1'b1) tx_seen.push_back(b);
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge aclk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    check_eq("aw_w_ready", {30'h0, awready, wready}, 32'h3);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    check_eq("bvalid", {31'h0, bvalid}, 32'h1);
    check_eq("bresp", {30'h0, bresp}, 32'h0);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (arready !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    check_eq("arready", {31'h0, arready}, 32'h1);
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (rvalid !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    check_eq("rresp", {30'h0, rresp}, 32'h0);
    data = rdata;
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check_eq(tag, d, exp);
  endtask

  task automatic send_loop(input logic [7:0] b);
    axi_write(32'h8, {24'h0, b}, 4'hF);
    if (m_rx.size() < 16) m_rx.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic drain_rx(input int n);
    logic [31:0] exp;
    for (int i = 0; i < n; i++) begin
      exp = (m_rx.size() != 0) ? {23'h0, 1'b1, m_rx.pop_front()} : 32'h0;
      check_reg("rx_data", 32'hC, exp);
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drive = bits[i];
      repeat (DIV) @(negedge aclk);
    end
    rx_drive = 1'b1;
    repeat (3 * DIV) @(negedge aclk);
  endtask

  initial begin
    logic [7:0] b;
    int nb;
    n_checks = 0; n_pass = 0; m_ovr = 1'b0; m_ferr = 1'b0; m_tx_cnt = 0;
    aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0;
    rready = 1'b0; awaddr = 32'h0; wdata = 32'h0; wstrb = 4'h0; araddr = 32'h0;
    rx_drive = 1'b1; loop_en = 1'b0;
    repeat (5) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);

    check_eq("rst_tx_serial", {31'h0, tx_serial}, 32'h1);
    check_eq("rst_handshakes", {27'h0, awready, wready, arready, bvalid, rvalid}, 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_resp", {28'h0, bresp, rresp}, 32'h0);
    check_reg("rst_status", 32'h4, exp_status());
    check_reg("rst_control", 32'h0, 32'h0);
    check_reg("unmapped_0x10", 32'h10, 32'h0);
    check_reg("rx_empty_read", 32'hC, 32'h0);
    check_reg("tx_data_read", 32'h8, 32'h0);

    // bit timing of a single 0x55 frame, with TX_BUSY seen mid-frame
    axi_write(32'h0, 32'h1, 4'hF);
    @(negedge aclk);
    fork
      begin : measure
        int n, run;
        logic lvl;
        logic [9:0] fb;
        fb = {1'b1, 8'h55, 1'b0};
        n = 0;
        while (tx_serial !== 1'b0 && n < 64) begin @(negedge aclk); n++; end
        check_eq("tx_start_edge", {31'h0, (n < 64)}, 32'h1);
        for (int s = 0; s < 10; s++) begin
          lvl = fb[s]; run = 0;
          while (tx_serial === lvl && run < DIV + 4) begin @(negedge aclk); run++; end
          check_eq($sformatf("bit%0d_len", s), run, (s == 9) ? DIV + 4 : DIV);
        end
      end
      begin : poke
        axi_write(32'h8, 32'h55, 4'hF);
        check_reg("tx_busy_status", 32'h4, exp_status() | 32'h10);
      end
    join
    repeat (2 * DIV) @(negedge aclk);
    check_eq("mon_count_55", tx_seen.size(), 1);
    if (tx_seen.size() != 0) check_eq("mon_byte_55", {24'h0, tx_seen.pop_front()}, 32'h55);
    check_reg("idle_status", 32'h4, exp_status());

    // TX FIFO fills at 16 with transmitter disabled, the 17th byte is dropped
    axi_write(32'h0, 32'h0, 4'hF);
    tx_seen.delete();
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      axi_write(32'h8, {24'h0, b}, 4'hF);
      if (m_txq.size() < 16) m_txq.push_back(b);
    end
    m_tx_cnt = m_txq.size();
    check_reg("tx_full_status", 32'h4, exp_status());
    axi_write(32'h0, 32'h0, 4'hE);
    check_reg("strb0_control", 32'h0, 32'h0);
    axi_write(32'h0, 32'h1, 4'hF);
    m_tx_cnt = 0;
    repeat (17 * FRAME) @(negedge aclk);
    check_eq("tx_full_count", tx_seen.size(), 16);
    while (tx_seen.size() != 0 && m_txq.size() != 0)
      check_eq("tx_full_byte", {24'h0, tx_seen.pop_front()}, {24'h0, m_txq.pop_front()});
    check_reg("tx_drained_status", 32'h4, exp_status());

    // loopback with the fixed pattern, then a random burst
    loop_en = 1'b1;
    axi_write(32'h0, 32'h3, 4'hF);
    check_reg("control_rw", 32'h0, 32'h3);
    for (int i = 0; i < 4; i++) send_loop(8'h41 + 8'(i));
    repeat (6 * FRAME) @(negedge aclk);
    check_reg("loop_status", 32'h4, exp_status());
    drain_rx(4);
    check_reg("loop_empty_status", 32'h4, exp_status());
    nb = $urandom_range(3, 10);
    for (int i = 0; i < nb; i++) send_loop(8'($urandom));
    repeat ((nb + 2) * FRAME) @(negedge aclk);
    check_reg("rand_loop_status", 32'h4, exp_status());
    drain_rx(nb + 1);

    // 17 frames into a 16-entry RX FIFO
    for (int i = 0; i < 17; i++) send_loop(8'($urandom));
    repeat (19 * FRAME) @(negedge aclk);
    check_reg("overrun_status", 32'h4, exp_status());
    drain_rx(16);
    check_reg("overrun_drained", 32'h4, exp_status());

    // externally driven frames: good, bad stop bit, false start
    loop_en = 1'b0;
    b = 8'($urandom);
    drive_frame(b, 1'b1);
    m_rx.push_back(b);
    drive_frame(8'hA5, 1'b0);
    m_ferr = 1'b1;
    rx_drive = 1'b0;
    repeat (DIV / 4) @(negedge aclk);
    rx_drive = 1'b1;
    repeat (12 * DIV) @(negedge aclk);
    check_reg("frame_err_status", 32'h4, exp_status());
    drain_rx(2);
    axi_write(32'h0, 32'h7, 4'hF);
    m_ovr = 1'b0; m_ferr = 1'b0;
    check_reg("clr_err_status", 32'h4, exp_status());
    check_reg("clr_err_control", 32'h0, 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
